// File: rtl/uart_pkg.sv
// Shared UART types and helpers, used by the configurable receiver and the future transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample prescaler: one-cycle tick every max(baud_div,1) clocks, restartable by clear.
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             clear,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_r;
  logic [DIV_W-1:0] last_s;

  // Terminal count; a divider of 0 behaves like 1
  always_comb begin
    if (baud_div == {DIV_W{1'b0}}) begin
      last_s = {DIV_W{1'b0}};
    end else begin
      last_s = baud_div - DIV_W'(1);
    end
  end

  // >= keeps the counter from running away if baud_div shrinks mid-count
  assign tick = !clear && (cnt_r >= last_s);

  // Prescaler counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {DIV_W{1'b0}};
    end else if (clear || tick) begin
      cnt_r <= {DIV_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver with runtime parity / stop-bit configuration,
// majority-vote sampling, error flags and a valid/ready output register.
module uart_rx_cfg import uart_pkg::*; #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic [1:0]           parity_mode,
  input  logic                 stop2,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [SW-1:0] S_LO   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_HI   = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_END  = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  logic [1:0]           sync_r;
  logic                 rx_s;
  logic                 rx_prev_r;
  rx_state_t            state_r;
  logic [SW-1:0]        s_cnt_r;
  logic [BW-1:0]        bit_cnt_r;
  logic [1:0]           samp_r;
  logic [DATA_BITS-1:0] data_r;
  parity_t              par_mode_r;
  parity_t              cfg_par_s;
  logic                 stop2_r;
  logic                 stop_second_r;
  logic                 par_bit_r;
  logic                 par_err_r;
  logic                 frm_err_r;
  logic                 done_r;
  logic                 start_s;
  logic                 tick_s;
  logic                 vote_s;
  logic                 brk_s;

  assign rx_s    = sync_r[1];
  assign start_s = (state_r == IDLE) && rx_prev_r && !rx_s;
  assign vote_s  = maj3(samp_r[0], samp_r[1], rx_s);
  assign busy    = (state_r != IDLE);
  assign brk_s   = frm_err_r && (data_r == {DATA_BITS{1'b0}}) &&
                   ((par_mode_r == PAR_NONE) || !par_bit_r);

  // Reserved parity encoding falls back to no parity
  always_comb begin
    case (parity_mode)
      2'd1:    cfg_par_s = PAR_EVEN;
      2'd2:    cfg_par_s = PAR_ODD;
      default: cfg_par_s = PAR_NONE;
    endcase
  end

  uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .baud_div (baud_div),
    .clear    (start_s),
    .tick     (tick_s)
  );

  // Two-flop synchroniser for the pad input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], rx};
    end
  end

  // Frame FSM: bit timing, majority sampling, shift register and error capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_prev_r     <= 1'b0;
      state_r       <= IDLE;
      s_cnt_r       <= {SW{1'b0}};
      bit_cnt_r     <= {BW{1'b0}};
      samp_r        <= 2'b00;
      data_r        <= {DATA_BITS{1'b0}};
      par_mode_r    <= PAR_NONE;
      stop2_r       <= 1'b0;
      stop_second_r <= 1'b0;
      par_bit_r     <= 1'b0;
      par_err_r     <= 1'b0;
      frm_err_r     <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      done_r    <= 1'b0;
      rx_prev_r <= rx_s;
      if (start_s) begin
        state_r       <= START;
        s_cnt_r       <= {SW{1'b0}};
        bit_cnt_r     <= {BW{1'b0}};
        stop_second_r <= 1'b0;
        par_bit_r     <= 1'b0;
        par_err_r     <= 1'b0;
        frm_err_r     <= 1'b0;
        par_mode_r    <= cfg_par_s;
        stop2_r       <= stop2;
      end else if ((state_r != IDLE) && tick_s) begin
        s_cnt_r <= (s_cnt_r == S_END) ? {SW{1'b0}} : s_cnt_r + SW'(1);
        if (s_cnt_r == S_LO)  samp_r[0] <= rx_s;
        if (s_cnt_r == S_MID) samp_r[1] <= rx_s;
        if (s_cnt_r == S_HI) begin
          case (state_r)
            START: state_r <= vote_s ? IDLE : DATA;
            DATA: begin
              data_r <= {vote_s, data_r[DATA_BITS-1:1]};
              if (bit_cnt_r == B_LAST) begin
                bit_cnt_r <= {BW{1'b0}};
                state_r   <= (par_mode_r == PAR_NONE) ? STOP : PARITY;
              end else begin
                bit_cnt_r <= bit_cnt_r + BW'(1);
              end
            end
            PARITY: begin
              par_bit_r <= vote_s;
              par_err_r <= (par_mode_r == PAR_ODD) ? ~(^data_r ^ vote_s) : (^data_r ^ vote_s);
              state_r   <= STOP;
            end
            STOP: begin
              // A low stop bit ends the frame at once; a second stop bit is then not sampled
              if (!vote_s) begin
                frm_err_r <= 1'b1;
                state_r   <= IDLE;
                done_r    <= 1'b1;
              end else if (stop2_r && !stop_second_r) begin
                stop_second_r <= 1'b1;
              end else begin
                state_r <= IDLE;
                done_r  <= 1'b1;
              end
            end
            default: state_r <= IDLE;
          endcase
        end
      end
    end
  end

  // Output register with valid/ready hand-off and overrun detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data     <= {DATA_BITS{1'b0}};
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      break_det   <= 1'b0;
      overrun_err <= 1'b0;
    end else if (done_r) begin
      if (!rx_valid || rx_ready) begin
        rx_data     <= data_r;
        parity_err  <= par_err_r;
        frame_err   <= frm_err_r;
        break_det   <= brk_s;
        rx_valid    <= 1'b1;
        overrun_err <= 1'b0;
      end else begin
        overrun_err <= 1'b1;
      end
    end else begin
      overrun_err <= 1'b0;
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: frames are driven bit by bit at 64 clocks per bit.
module tb_uart_rx_cfg;

  localparam int BIT = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] baud_div = 16'd4;
  logic [1:0]  parity_mode = 2'd0;
  logic        stop2 = 1'b0;
  logic        rx = 1'b1;
  logic        rx_ready = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_valid, parity_err, frame_err, break_det, overrun_err, busy;

  typedef struct packed {
    logic [7:0] data;
    logic       pe;
    logic       fe;
    logic       brk;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   words = 0;
  int   ovr_cnt = 0;
  int   words_snap;
  logic v_prev = 1'b0;

  uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .DIV_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .baud_div    (baud_div),
    .parity_mode (parity_mode),
    .stop2       (stop2),
    .rx          (rx),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .break_det   (break_det),
    .overrun_err (overrun_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input logic pb,
                            input logic two, input logic s1, input logic s2, input bit expect_word);
    exp_t e;
    logic x;
    parity_mode = pm;
    stop2       = two;
    x     = (^d) ^ pb;
    e.data = d;
    e.pe   = (pm == 2'd1) ? x : ((pm == 2'd2) ? ~x : 1'b0);
    e.fe   = !s1 || (two && !s2);
    e.brk  = e.fe && (d == 8'h00) && ((pm == 2'd0) || !pb);
    if (expect_word) exp_q.push_back(e);
    hold(1'b0, BIT);
    for (int i = 0; i < 8; i++) hold(d[i], BIT);
    if (pm != 2'd0) hold(pb, BIT);
    hold(s1, BIT);
    if (two && s1) hold(s2, BIT);
    hold(1'b1, 2 * BIT);
  endtask

  // Monitor: every new word is popped from the scoreboard and compared
  always @(negedge clk) begin
    if (rx_valid && !v_prev) begin
      words++;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_word", exp_q.size(), 32'd1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("rx_data", {24'd0, rx_data}, {24'd0, e.data});
        check_eq("parity_err", {31'd0, parity_err}, {31'd0, e.pe});
        check_eq("frame_err", {31'd0, frame_err}, {31'd0, e.fe});
        check_eq("break_det", {31'd0, break_det}, {31'd0, e.brk});
      end
    end
    if (overrun_err) ovr_cnt++;
    v_prev <= rx_valid;
  end

  initial begin
    repeat (5) @(negedge clk);
    check_eq("reset_valid", {31'd0, rx_valid}, 32'd0);
    check_eq("reset_data", {24'd0, rx_data}, 32'd0);
    check_eq("reset_busy", {31'd0, busy}, 32'd0);
    check_eq("reset_flags", {28'd0, parity_err, frame_err, break_det, overrun_err}, 32'd0);
    rst_n = 1'b1;
    hold(1'b1, BIT);

    send_frame(8'hA5, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check_eq("busy_after_a5", {31'd0, busy}, 32'd0);
    check_eq("no_overrun_a5", ovr_cnt, 32'd0);

    // False start: 3 ticks low, majority of mid samples high
    words_snap = words;
    hold(1'b0, 12);
    hold(1'b1, 8);
    check_eq("busy_in_false_start", {31'd0, busy}, 32'd1);
    hold(1'b1, 60);
    check_eq("busy_after_false_start", {31'd0, busy}, 32'd0);
    hold(1'b1, 2 * BIT);
    check_eq("false_start_words", words, words_snap);

    send_frame(8'h0F, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    send_frame(8'h0F, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    send_frame(8'h03, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

    // 0xFF with a 4-clock low glitch around the middle sample of data bit 3
    parity_mode = 2'd0;
    stop2 = 1'b0;
    exp_q.push_back('{data: 8'hFF, pe: 1'b0, fe: 1'b0, brk: 1'b0});
    hold(1'b0, BIT);
    hold(1'b1, 3 * BIT);
    hold(1'b1, 35);
    hold(1'b0, 4);
    hold(1'b1, 25);
    hold(1'b1, 5 * BIT);
    hold(1'b1, 2 * BIT);

    // Break: line held low for 12 bit times yields exactly one word
    exp_q.push_back('{data: 8'h00, pe: 1'b0, fe: 1'b1, brk: 1'b1});
    words_snap = words;
    hold(1'b0, 12 * BIT);
    hold(1'b1, 3 * BIT);
    check_eq("break_word_count", words, words_snap + 1);

    // Overrun: second frame dropped while first unaccepted
    rx_ready = 1'b0;
    send_frame(8'h11, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    send_frame(8'h22, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("overrun_pulses", ovr_cnt, 32'd1);
    check_eq("overrun_keep_data", {24'd0, rx_data}, 32'h11);
    check_eq("overrun_keep_valid", {31'd0, rx_valid}, 32'd1);
    rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("valid_dropped", {31'd0, rx_valid}, 32'd0);

    send_frame(8'h3C, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    send_frame(8'h3C, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

    // Asynchronous reset in the middle of the data bits
    rx_ready = 1'b0;
    send_frame(8'h5A, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    hold(1'b0, BIT);
    hold(1'b1, BIT);
    hold(1'b0, BIT);
    hold(1'b1, 30);
    rst_n = 1'b0;
    #1;
    check_eq("midreset_valid", {31'd0, rx_valid}, 32'd0);
    check_eq("midreset_data", {24'd0, rx_data}, 32'd0);
    check_eq("midreset_busy", {31'd0, busy}, 32'd0);
    check_eq("midreset_flags", {28'd0, parity_err, frame_err, break_det, overrun_err}, 32'd0);
    @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    rx_ready = 1'b1;
    hold(1'b1, BIT);
    send_frame(8'h96, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

    check_eq("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
